foreground_bbox_stats: RTL
==========================

# foreground_bbox_stats

Downstream consumer of the background-subtraction stage. It reads the 128x128 grayscale foreground mask (one byte per pixel, 255 = foreground, 0 = background) back out of a selected serial SRAM through the shared SRAM command interface. It produces a foreground pixel count, a bounding box and centroid sums for the Raspberry Pi host, and signals completion with a single-cycle `job_done` pulse.

## Interface
Parameters:
- `IMG_W_LOG2`, default 7: log2 of image width.
- `IMG_H_LOG2`, default 7: log2 of image height. Pixel count `N = 2^(IMG_W_LOG2+IMG_H_LOG2)` (16384 at the defaults).

Ports:
- `clk` input 1: single system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `sram_select_in` input 2: index of the SRAM holding the mask.
- `inst_address` input 24: start byte address of the mask.
- `execute` input 1: start request, level-sampled in IDLE.
- `mem_out` input 4: serial read data, one bit per SRAM.
- `io_valid` input 4: per-SRAM qualifier for `mem_out`.
- `rw_done` input 4: per-SRAM transfer-complete pulse.
- `inst` output 8 x 4: per-SRAM opcode (0 = none, 3 = read).
- `address` output 24 x 4: per-SRAM start address.
- `byte_length` output 24 x 4: per-SRAM transfer length.
- `busy` output 1: high in every state other than IDLE.
- `job_done` output 1: one-cycle completion pulse.
- `error` output 1: high when the last job received fewer than N whole bytes. Held until the next start.
- `fg_count` output 15: number of foreground pixels, 0..16384.
- `bbox_valid` output 1: `fg_count != 0`.
- `x_min`, `x_max`, `y_min`, `y_max` output 7 each: inclusive bounding box.
- `sum_x`, `sum_y` output 21 each: sums of the foreground x and y coordinates. The maximum value is 127*16384 = 2,080,768, so no overflow is possible.

## Operation
States: IDLE, ISSUE, RECEIVE, FLUSH, DONE.

- **IDLE**
  - All `inst`/`address`/`byte_length` entries are 0.
  - When `execute` = 1: latch `s = sram_select_in` and the address, clear the accumulators, go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `inst[s]=3`, `address[s]=latched address`, `byte_length[s]=N`. All other entries stay 0.
  - Next state is RECEIVE. The command fields return to 0 on entry to RECEIVE.
- **RECEIVE**
  - Each cycle with `io_valid[s]=1` shifts `mem_out[s]` into the byte register, MSB first.
  - On the 8th bit, the byte is complete:
    - Pixel index `p` = bytes received so far. `x = p[6:0]`, `y = p[13:7]` (row-major).
    - A nonzero byte is foreground: increment `fg_count`, update min/max, add x to `sum_x` and y to `sum_y`.
  - Bytes beyond N are ignored.
  - `rw_done[s]` moves the state to FLUSH. A bit valid in the same cycle is still counted.
- **FLUSH** (one cycle)
  - Retires the last pixel update.
  - `error = (bytes_received < N)`. A partial byte is discarded and counts as short.
- **DONE** (one cycle)
  - Loads the output registers from the accumulators and pulses `job_done`, then returns to IDLE.
  - If `fg_count = 0`: `bbox_valid=0` and all bbox fields are 0.

Other rules:
- Accumulator init: `x_min=y_min=127`, `x_max=y_max=0`, counts and sums 0.
- `io_valid`/`mem_out`/`rw_done` lines other than index `s` are ignored.
- `execute` outside IDLE is ignored.
- Results and `error` hold until the next DONE.

## Timing
- Reset: async assert, synchronous-safe deassert.
  - All outputs go to 0, the state goes to IDLE.
  - A reset mid-job abandons the read without an abort command. The SRAM controller is expected to complete or flush it independently.
- Command timing: `execute` sampled at edge k gives `inst[s]=3` during cycle k+1 and 0 from k+2.
- Pixel latency: 8 valid bits to one pixel update, which is applied on the edge of the 8th bit.
- Completion: `rw_done` at edge m gives FLUSH at m+1, then outputs updated and `job_done=1` at m+2 for exactly one cycle. `busy` falls at m+3.
- Minimum job length: N*8 valid cycles plus 4.

## Structure
- Shared package `accel_pkg`:
  - `GS_IMG_BYTE_LENGTH=16384`, `RGB_IMG_BYTE_LENGTH=49152`.
  - Opcodes `SRAM_NOP=0`, `SRAM_WRITE=2`, `SRAM_READ=3`.
  - Image dimension constants.
  - State enum `stats_state_t`.
- One sub-module, `serial_byte_deserializer`:
  - Inputs: bit, valid, clear.
  - Outputs: byte, byte_strobe.
  - Contains the 3-bit counter and shift register.
- Top-level holds the FSM, pixel index counter and accumulators.

## Test plan
- **All-zero mask, s=1, address 0x000100:** one ISSUE cycle with `inst[1]=3`, `byte_length[1]=16384`. After `rw_done`: `fg_count=0`, `bbox_valid=0`, bbox 0, `error=0`, `job_done` exactly 2 cycles after `rw_done`.
- **Single 255 pixel at index 130 (x=2, y=1):** `fg_count=1`, `x_min=x_max=2`, `y_min=y_max=1`, `sum_x=2`, `sum_y=1`.
- **Full 255 mask:** `fg_count=16384`, bbox (0,0)-(127,127), `sum_x=sum_y=1040384`.
- **`rw_done` after 100 bytes plus 3 bits:** `error=1`, only pixels 0..99 counted. `execute` asserted mid-job has no effect.
- **Reset asserted mid-RECEIVE, then a restart with s=3:** all outputs 0 immediately on reset. The new job uses only lane 3 and gives correct results. Traffic on lanes 0..2 is ignored.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator constants, SRAM command payload and the stats FSM state type.
package accel_pkg;

    localparam int unsigned NUM_SRAM            = 4;
    localparam int unsigned SRAM_SEL_W          = 2;
    localparam int unsigned INST_W              = 8;
    localparam int unsigned SRAM_ADDR_W         = 24;

    localparam int unsigned IMG_W_LOG2_DEF      = 7;
    localparam int unsigned IMG_H_LOG2_DEF      = 7;
    localparam int unsigned GS_IMG_BYTE_LENGTH  = 16384;
    localparam int unsigned RGB_IMG_BYTE_LENGTH = 49152;

    localparam logic [INST_W-1:0] SRAM_NOP   = 8'd0;
    localparam logic [INST_W-1:0] SRAM_WRITE = 8'd2;
    localparam logic [INST_W-1:0] SRAM_READ  = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RECEIVE,
        ST_FLUSH,
        ST_DONE
    } stats_state_t;

    typedef struct packed {
        logic [INST_W-1:0]      inst;
        logic [SRAM_ADDR_W-1:0] address;
        logic [SRAM_ADDR_W-1:0] byte_length;
    } sram_cmd_t;

endpackage

// File: rtl/serial_byte_deserializer.sv
// Collects serial bits MSB first; the completed byte and its strobe appear combinationally
// alongside the 8th valid bit so the consumer can act on that same edge.
module serial_byte_deserializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_bit,
    input  logic       bit_valid,
    input  logic       clear,
    output logic [7:0] byte_data_c,
    output logic       byte_strobe_c
);

    logic [2:0] bit_cnt;
    logic [6:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (bit_valid) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift_q <= {shift_q[5:0], ser_bit};
        end
    end

    assign byte_strobe_c = bit_valid && (bit_cnt == 3'd7);
    assign byte_data_c   = {shift_q, ser_bit};

endmodule

// File: rtl/foreground_bbox_stats.sv
// Reads a foreground mask back from one serial SRAM and reports pixel count,
// bounding box and centroid sums, finishing with a one-cycle job_done.
module foreground_bbox_stats
    import accel_pkg::*;
#(
    parameter int unsigned IMG_W_LOG2 = IMG_W_LOG2_DEF,
    parameter int unsigned IMG_H_LOG2 = IMG_H_LOG2_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [SRAM_SEL_W-1:0]                  sram_select_in,
    input  logic [SRAM_ADDR_W-1:0]                 inst_address,
    input  logic                                   execute,
    input  logic [NUM_SRAM-1:0]                    mem_out,
    input  logic [NUM_SRAM-1:0]                    io_valid,
    input  logic [NUM_SRAM-1:0]                    rw_done,
    output logic [NUM_SRAM-1:0][INST_W-1:0]        inst,
    output logic [NUM_SRAM-1:0][SRAM_ADDR_W-1:0]   address,
    output logic [NUM_SRAM-1:0][SRAM_ADDR_W-1:0]   byte_length,
    output logic                                   busy,
    output logic                                   job_done,
    output logic                                   error,
    output logic [IMG_W_LOG2+IMG_H_LOG2:0]         fg_count,
    output logic                                   bbox_valid,
    output logic [IMG_W_LOG2-1:0]                  x_min,
    output logic [IMG_W_LOG2-1:0]                  x_max,
    output logic [IMG_H_LOG2-1:0]                  y_min,
    output logic [IMG_H_LOG2-1:0]                  y_max,
    output logic [2*IMG_W_LOG2+IMG_H_LOG2-1:0]     sum_x,
    output logic [IMG_W_LOG2+2*IMG_H_LOG2-1:0]     sum_y
);

    localparam int unsigned PIX_LOG2 = IMG_W_LOG2 + IMG_H_LOG2;
    localparam int unsigned CNT_W    = PIX_LOG2 + 1;
    localparam int unsigned SX_W     = 2 * IMG_W_LOG2 + IMG_H_LOG2;
    localparam int unsigned SY_W     = IMG_W_LOG2 + 2 * IMG_H_LOG2;
    localparam int unsigned N_PIX    = 2 ** PIX_LOG2;

    stats_state_t                 state, state_nx;
    logic [SRAM_SEL_W-1:0]        sel_q;
    sram_cmd_t [NUM_SRAM-1:0]     cmd_q, cmd_nx;

    logic                         start_c, valid_c, done_c, pix_c, fg_c, room_c;
    logic [7:0]                   byte_data_c;
    logic                         byte_strobe_c;
    logic [IMG_W_LOG2-1:0]        x_c;
    logic [IMG_H_LOG2-1:0]        y_c;

    logic [CNT_W-1:0]             bytes_q, acc_count;
    logic [IMG_W_LOG2-1:0]        acc_xmin, acc_xmax;
    logic [IMG_H_LOG2-1:0]        acc_ymin, acc_ymax;
    logic [SX_W-1:0]              acc_sx;
    logic [SY_W-1:0]              acc_sy;

    assign start_c = (state == ST_IDLE) && execute;
    assign valid_c = (state == ST_RECEIVE) && io_valid[sel_q];
    assign done_c  = (state == ST_RECEIVE) && rw_done[sel_q];
    assign room_c  = bytes_q < CNT_W'(N_PIX);
    assign pix_c   = byte_strobe_c && room_c;
    assign fg_c    = pix_c && (byte_data_c != 8'd0);
    assign x_c     = bytes_q[IMG_W_LOG2-1:0];
    assign y_c     = bytes_q[PIX_LOG2-1:IMG_W_LOG2];

    serial_byte_deserializer u_deser (
        .clk           (clk),
        .rst_n         (rst_n),
        .ser_bit       (mem_out[sel_q]),
        .bit_valid     (valid_c),
        .clear         (start_c),
        .byte_data_c   (byte_data_c),
        .byte_strobe_c (byte_strobe_c)
    );

    // State register and latched lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nx;
            if (start_c) begin
                sel_q <= sram_select_in;
            end
        end
    end

    // Next state and next SRAM command; the command lives for the ISSUE cycle only
    always_comb begin
        state_nx = state;
        cmd_nx   = '0;
        case (state)
            ST_IDLE: begin
                if (execute) begin
                    state_nx = ST_ISSUE;
                    cmd_nx[sram_select_in] = '{inst: SRAM_READ, address: inst_address,
                                               byte_length: SRAM_ADDR_W'(N_PIX)};
                end
            end
            ST_ISSUE:   state_nx = ST_RECEIVE;
            ST_RECEIVE: if (done_c) state_nx = ST_FLUSH;
            ST_FLUSH:   state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Pixel index and accumulators; bytes past the last pixel leave everything untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || start_c) begin
            bytes_q   <= '0;
            acc_count <= '0;
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
            acc_sx    <= '0;
            acc_sy    <= '0;
        end else if (pix_c) begin
            bytes_q <= bytes_q + CNT_W'(1);
            if (fg_c) begin
                acc_count <= acc_count + CNT_W'(1);
                if (x_c < acc_xmin) acc_xmin <= x_c;
                if (x_c > acc_xmax) acc_xmax <= x_c;
                if (y_c < acc_ymin) acc_ymin <= y_c;
                if (y_c > acc_ymax) acc_ymax <= y_c;
                acc_sx <= acc_sx + SX_W'(x_c);
                acc_sy <= acc_sy + SY_W'(y_c);
            end
        end
    end

    // Registered outputs: results publish on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            error      <= 1'b0;
            fg_count   <= '0;
            bbox_valid <= 1'b0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
        end else begin
            cmd_q    <= cmd_nx;
            busy     <= (state_nx != ST_IDLE);
            job_done <= (state == ST_FLUSH);
            if (state == ST_FLUSH) begin
                error      <= room_c;
                fg_count   <= acc_count;
                bbox_valid <= (acc_count != '0);
                x_min      <= (acc_count != '0) ? acc_xmin : '0;
                x_max      <= (acc_count != '0) ? acc_xmax : '0;
                y_min      <= (acc_count != '0) ? acc_ymin : '0;
                y_max      <= (acc_count != '0) ? acc_ymax : '0;
                sum_x      <= acc_sx;
                sum_y      <= acc_sy;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRAM; i++) begin : g_cmd
        assign inst[i]        = cmd_q[i].inst;
        assign address[i]     = cmd_q[i].address;
        assign byte_length[i] = cmd_q[i].byte_length;
    end

endmodule
